// File: rtl/fetch_pc_gen.sv
// Dual-issue fetch PC generator with a one-cycle fetch-to-decode staging register.
// Next PC priority: reset, kill redirect, stall hold, prediction, sequential.
module fetch_pc_gen #(
    parameter int unsigned          PC_WIDTH  = 32,
    parameter int unsigned          GHR_WIDTH = 10,
    parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_stall,
    input  logic                 i_kill,
    input  logic [PC_WIDTH-1:0]  i_kill_pc,
    input  logic                 i_pred_jmp,
    input  logic [PC_WIDTH-1:0]  i_pc_btb,
    input  logic [GHR_WIDTH-1:0] i_ghr,
    output logic [PC_WIDTH-1:0]  o_pc_1,
    output logic [PC_WIDTH-1:0]  o_pc_2,
    output logic                 o_inst_vld_1,
    output logic                 o_inst_vld_2,
    output logic                 o_dec_vld_1,
    output logic                 o_dec_vld_2,
    output logic [PC_WIDTH-1:0]  o_dec_pc,
    output logic                 o_dec_pred_jmp,
    output logic [PC_WIDTH-1:0]  o_dec_pred_addr,
    output logic [GHR_WIDTH-1:0] o_dec_ghr
);

    localparam logic [1:0] StBoot = 2'd0;
    localparam logic [1:0] StRun  = 2'd1;
    localparam logic [1:0] StHold = 2'd2;

    logic [1:0]           state_q;
    logic [PC_WIDTH-1:0]  pc_q;
    logic [PC_WIDTH-1:0]  pc_seq;
    logic [PC_WIDTH-1:0]  pc_pred_next;
    logic [PC_WIDTH-1:0]  kill_pc_aligned;
    logic                 fetch_active;
    logic                 dec_vld_1_q;
    logic                 dec_vld_2_q;
    logic [PC_WIDTH-1:0]  dec_pc_q;
    logic                 dec_pred_jmp_q;
    logic [PC_WIDTH-1:0]  dec_pred_addr_q;
    logic [GHR_WIDTH-1:0] dec_ghr_q;

    always_comb begin
        fetch_active    = (state_q != StBoot);
        // An odd-word PC only fetches one slot, so the next pair starts 4 bytes on.
        pc_seq          = pc_q[2] ? (pc_q + PC_WIDTH'(4)) : (pc_q + PC_WIDTH'(8));
        pc_pred_next    = i_pred_jmp ? i_pc_btb : pc_seq;
        kill_pc_aligned = {i_kill_pc[PC_WIDTH-1:2], 2'b00};

        o_pc_1          = pc_q;
        o_pc_2          = pc_q + PC_WIDTH'(4);
        o_inst_vld_1    = fetch_active;
        o_inst_vld_2    = fetch_active & ~pc_q[2] & ~i_pred_jmp;

        o_dec_vld_1     = dec_vld_1_q;
        o_dec_vld_2     = dec_vld_2_q;
        o_dec_pc        = dec_pc_q;
        o_dec_pred_jmp  = dec_pred_jmp_q;
        o_dec_pred_addr = dec_pred_addr_q;
        o_dec_ghr       = dec_ghr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= StBoot;
            pc_q            <= RESET_PC;
            dec_vld_1_q     <= 1'b0;
            dec_vld_2_q     <= 1'b0;
            dec_pc_q        <= '0;
            dec_pred_jmp_q  <= 1'b0;
            dec_pred_addr_q <= '0;
            dec_ghr_q       <= '0;
        end else if (i_kill) begin
            state_q     <= StRun;
            pc_q        <= kill_pc_aligned;
            dec_vld_1_q <= 1'b0;
            dec_vld_2_q <= 1'b0;
        end else if (state_q == StBoot) begin
            state_q     <= StRun;
            dec_vld_1_q <= 1'b0;
            dec_vld_2_q <= 1'b0;
        end else if (i_stall) begin
            state_q <= StHold;
        end else begin
            // Advancing cycle (RUN, or HOLD just released): issue and stage the packet.
            state_q         <= StRun;
            pc_q            <= pc_pred_next;
            dec_vld_1_q     <= o_inst_vld_1;
            dec_vld_2_q     <= o_inst_vld_2;
            dec_pc_q        <= pc_q;
            dec_pred_jmp_q  <= i_pred_jmp;
            dec_pred_addr_q <= pc_pred_next;
            dec_ghr_q       <= i_ghr;
        end
    end

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed self-checking bench for fetch_pc_gen with hand-computed expectations.
module tb_fetch_pc_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_stall;
    logic        i_kill;
    logic [31:0] i_kill_pc;
    logic        i_pred_jmp;
    logic [31:0] i_pc_btb;
    logic [9:0]  i_ghr;
    logic [31:0] o_pc_1;
    logic [31:0] o_pc_2;
    logic        o_inst_vld_1;
    logic        o_inst_vld_2;
    logic        o_dec_vld_1;
    logic        o_dec_vld_2;
    logic [31:0] o_dec_pc;
    logic        o_dec_pred_jmp;
    logic [31:0] o_dec_pred_addr;
    logic [9:0]  o_dec_ghr;

    int n_chk  = 0;
    int n_pass = 0;

    fetch_pc_gen #(
        .PC_WIDTH (32),
        .GHR_WIDTH(10),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .i_stall        (i_stall),
        .i_kill         (i_kill),
        .i_kill_pc      (i_kill_pc),
        .i_pred_jmp     (i_pred_jmp),
        .i_pc_btb       (i_pc_btb),
        .i_ghr          (i_ghr),
        .o_pc_1         (o_pc_1),
        .o_pc_2         (o_pc_2),
        .o_inst_vld_1   (o_inst_vld_1),
        .o_inst_vld_2   (o_inst_vld_2),
        .o_dec_vld_1    (o_dec_vld_1),
        .o_dec_vld_2    (o_dec_vld_2),
        .o_dec_pc       (o_dec_pc),
        .o_dec_pred_jmp (o_dec_pred_jmp),
        .o_dec_pred_addr(o_dec_pred_addr),
        .o_dec_ghr      (o_dec_ghr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        i_stall    = 1'b0;
        i_kill     = 1'b0;
        i_kill_pc  = '0;
        i_pred_jmp = 1'b0;
        i_pc_btb   = '0;
        i_ghr      = '0;
        tick();
        tick();
        rst = 1'b0;

        // BOOT cycle: reset values, no fetch valid
        check("boot_pc1", o_pc_1, 32'h0);
        check("boot_ivld1", o_inst_vld_1, 0);
        check("boot_ivld2", o_inst_vld_2, 0);
        check("boot_dvld1", o_dec_vld_1, 0);
        check("boot_dvld2", o_dec_vld_2, 0);
        check("boot_dpc", o_dec_pc, 32'h0);
        check("boot_daddr", o_dec_pred_addr, 32'h0);
        check("boot_dghr", o_dec_ghr, 0);
        check("boot_djmp", o_dec_pred_jmp, 0);

        tick();
        i_ghr = 10'h2A3;
        #1;
        check("run0_pc1", o_pc_1, 32'h0);
        check("run0_pc2", o_pc_2, 32'h4);
        check("run0_ivld1", o_inst_vld_1, 1);
        check("run0_ivld2", o_inst_vld_2, 1);
        check("run0_dvld1", o_dec_vld_1, 0);

        tick();
        i_ghr = 10'h155;
        check("run1_pc1", o_pc_1, 32'h8);
        check("run1_dpc", o_dec_pc, 32'h0);
        check("run1_dghr", o_dec_ghr, 32'h2A3);
        check("run1_dvld1", o_dec_vld_1, 1);
        check("run1_dvld2", o_dec_vld_2, 1);
        check("run1_daddr", o_dec_pred_addr, 32'h8);

        // Predicted taken at 0x08 -> 0x100, slot 2 squashed
        i_pred_jmp = 1'b1;
        i_pc_btb   = 32'h100;
        #1;
        check("pred_ivld1", o_inst_vld_1, 1);
        check("pred_ivld2", o_inst_vld_2, 0);
        tick();
        i_pred_jmp = 1'b0;
        #1;
        check("pred_pc1", o_pc_1, 32'h100);
        check("pred_djmp", o_dec_pred_jmp, 1);
        check("pred_daddr", o_dec_pred_addr, 32'h100);
        check("pred_dvld2", o_dec_vld_2, 0);
        check("pred_dpc", o_dec_pc, 32'h8);
        check("pred_dghr", o_dec_ghr, 32'h155);

        // Kill to odd word 0x204
        i_kill    = 1'b1;
        i_kill_pc = 32'h204;
        tick();
        i_kill = 1'b0;
        #1;
        check("kill_pc1", o_pc_1, 32'h204);
        check("kill_ivld2", o_inst_vld_2, 0);
        check("kill_dvld1", o_dec_vld_1, 0);
        check("kill_dvld2", o_dec_vld_2, 0);
        tick();
        check("kill2_pc1", o_pc_1, 32'h208);
        check("kill2_ivld2", o_inst_vld_2, 1);
        check("kill2_dvld1", o_dec_vld_1, 1);
        check("kill2_dvld2", o_dec_vld_2, 0);
        check("kill2_dpc", o_dec_pc, 32'h204);
        check("kill2_daddr", o_dec_pred_addr, 32'h208);

        // Redirect to 0x38 so the decode register holds a live packet when stalling at 0x40
        i_kill    = 1'b1;
        i_kill_pc = 32'h38;
        tick();
        i_kill = 1'b0;
        tick();
        check("prestall_pc1", o_pc_1, 32'h40);
        check("prestall_dpc", o_dec_pc, 32'h38);
        i_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_pc1", o_pc_1, 32'h40);
            check("stall_ivld1", o_inst_vld_1, 1);
            check("stall_dpc", o_dec_pc, 32'h38);
            check("stall_dvld1", o_dec_vld_1, 1);
            check("stall_daddr", o_dec_pred_addr, 32'h40);
        end
        i_stall = 1'b0;
        tick();
        check("release_pc1", o_pc_1, 32'h48);
        check("release_dpc", o_dec_pc, 32'h40);

        // Kill and stall together; low bits of the target are dropped
        i_kill    = 1'b1;
        i_stall   = 1'b1;
        i_kill_pc = 32'h83;
        tick();
        i_kill  = 1'b0;
        i_stall = 1'b0;
        #1;
        check("ks_pc1", o_pc_1, 32'h80);
        check("ks_dvld1", o_dec_vld_1, 0);
        check("ks_dvld2", o_dec_vld_2, 0);

        // Reset while held
        i_stall = 1'b1;
        tick();
        check("hold_pc1", o_pc_1, 32'h80);
        rst = 1'b1;
        tick();
        rst     = 1'b0;
        i_stall = 1'b0;
        #1;
        check("rst_pc1", o_pc_1, 32'h0);
        check("rst_ivld1", o_inst_vld_1, 0);
        check("rst_dvld1", o_dec_vld_1, 0);
        check("rst_dpc", o_dec_pc, 32'h0);
        check("rst_daddr", o_dec_pred_addr, 32'h0);
        tick();
        check("rst_run_pc1", o_pc_1, 32'h0);
        check("rst_run_ivld1", o_inst_vld_1, 1);

        // Wrap-around
        i_kill    = 1'b1;
        i_kill_pc = 32'hFFFF_FFF8;
        tick();
        i_kill = 1'b0;
        #1;
        check("wrap_pc1", o_pc_1, 32'hFFFF_FFF8);
        check("wrap_pc2", o_pc_2, 32'hFFFF_FFFC);
        tick();
        check("wrap_next", o_pc_1, 32'h0);
        check("wrap_daddr", o_dec_pred_addr, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
- Front-end PC generator and fetch-to-decode staging register for the dual-issue core.
- Produces the two fetch PCs and slot valids each cycle; the branch predictor and the synchronous instruction memory consume them.
- Takes the same-cycle prediction (taken flag, BTB target, GHR snapshot) to select the next PC.
- Captures that prediction metadata alongside the fetched pair so decode and commit can train the predictor and detect mispredicts.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset; must be 4-byte aligned.
- PC_WIDTH, 32, PC width; equals RV32_PC_WIDTH.
- GHR_WIDTH, 10, global history width; equals GSH_GHR_WIDTH.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- i_stall  in  1  decode back-pressure: hold fetch PC and decode register
- i_kill  in  1  mispredict/exception redirect from commit
- i_kill_pc  in  PC_WIDTH  redirect target, 4-byte aligned
- i_pred_jmp  in  1  predictor: slot-1 predicted taken (BTB hit and taken)
- i_pc_btb  in  PC_WIDTH  predictor: BTB target for slot 1
- i_ghr  in  GHR_WIDTH  predictor: GHR snapshot for this fetch
- o_pc_1  out  PC_WIDTH  fetch PC slot 1, to predictor/imem
- o_pc_2  out  PC_WIDTH  fetch PC slot 2, always o_pc_1+4
- o_inst_vld_1  out  1  slot 1 fetch valid
- o_inst_vld_2  out  1  slot 2 fetch valid
- o_dec_vld_1  out  1  decode register slot 1 valid
- o_dec_vld_2  out  1  decode register slot 2 valid
- o_dec_pc  out  PC_WIDTH  PC of decode-register slot 1
- o_dec_pred_jmp  out  1  slot-1 taken prediction carried to decode
- o_dec_pred_addr  out  PC_WIDTH  predicted next PC of the packet
- o_dec_ghr  out  GHR_WIDTH  GHR snapshot carried to decode

Behaviour:
- States:
  - BOOT: one cycle after reset; no fetch valid.
  - RUN: issuing fetches.
  - HOLD: stalled.
- Reset (rst=1 at posedge):
  - State = BOOT; fetch PC = RESET_PC.
  - All o_inst_vld_* and o_dec_vld_* = 0.
  - o_dec_pc, o_dec_pred_addr, o_dec_ghr and o_dec_pred_jmp = 0.
  - rst has priority over everything, including mid-stall or same-cycle kill.
- BOOT -> RUN unconditionally next cycle; o_inst_vld_* are 0 in BOOT.
- Slot valids in RUN:
  - o_inst_vld_1 = 1.
  - o_inst_vld_2 = ~o_pc_1[2] & ~i_pred_jmp. Fetch pairs are 8-byte aligned; a predicted-taken slot 1 squashes slot 2.
- Next-PC priority (per cycle): rst > i_kill > i_stall > prediction > sequential.
  - i_kill: fetch PC <= i_kill_pc; both decode valids <= 0 next cycle; state RUN. The in-flight fetch is discarded. Kill overrides a simultaneous stall.
  - i_stall (no kill): fetch PC and decode register hold; state HOLD; o_inst_vld_* stay asserted with the same PCs (imem re-reads).
  - i_pred_jmp: fetch PC <= i_pc_btb.
  - Sequential: fetch PC <= o_pc_1[2] ? o_pc_1+4 : o_pc_1+8.
- Predicted next PC: the value loaded into the fetch PC by the prediction/sequential rule is also latched into o_dec_pred_addr.
- HOLD -> RUN when i_stall deasserts; the held PC is issued again with a fresh prediction.
- Decode register (1-cycle latency, aligned with the synchronous imem):
  - On an advancing RUN cycle, capture o_pc_1, o_inst_vld_1/2, i_pred_jmp, the selected next PC and i_ghr.
  - Contents appear on o_dec_* the following cycle.
  - In BOOT, capture valids = 0.
- Arithmetic: PC adds are modulo 2^PC_WIDTH; 32'hFFFF_FFF8+8 wraps to 0 with no flag.
- i_kill_pc[1:0] != 0 is illegal; implementation ignores bits [1:0] (forces to 0).

Test Plan:
- Reset then run, no predictions:
  - Cycles 0,1,2 after BOOT: o_pc_1 = 0, 8, 0x10; both slot valids 1.
  - o_dec_pc = 0 one cycle after o_pc_1 = 0; o_dec_ghr matches i_ghr of that cycle.
- i_pred_jmp=1 with i_pc_btb=0x100 at o_pc_1=0x08:
  - o_inst_vld_2 = 0 that cycle; next o_pc_1 = 0x100.
  - Decode register shows pred_jmp=1, pred_addr=0x100, vld_2=0.
- Kill to 0x204 (odd word):
  - Next o_pc_1 = 0x204, o_inst_vld_2 = 0; decode valids 0 for one cycle.
  - Following o_pc_1 = 0x208, pair valid.
- i_stall for 3 cycles at o_pc_1=0x40:
  - o_pc_1 stays 0x40 and o_dec_* unchanged throughout.
  - Release -> o_pc_1 0x48 next cycle.
- i_kill and i_stall together with i_kill_pc=0x80: o_pc_1 = 0x80 next cycle; decode valids 0.
- rst asserted during HOLD: outputs return to reset values; BOOT then o_pc_1 = RESET_PC. Then run sequentially from o_pc_1=0xFFFF_FFF8: next o_pc_1 wraps to 0.
